// File: rtl/sdpram_rd_pkg.sv
// Shared types and helpers for the 2048x9 SDPRAM read-side streamer.
package sdpram_rd_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 9;

    // A burst longer than the RAM would revisit locations, so cap it at one full pass.
    function automatic logic [31:0] clamp_len(input logic [31:0] len, input int addr_width);
        logic [31:0] full;
        full = 32'd1 << addr_width;
        return (len > full) ? full : len;
    endfunction

endpackage

// File: rtl/sdpram_rd_streamer.sv
// Read-side burst controller for the simple dual-port RAM.
// Turns (addr, len) commands into a valid/ready stream with a last marker.
// The RAM read clock enable doubles as the backpressure stall: while the
// consumer holds off, the RAM keeps its output and nothing is re-read.
// Optional feature: define SDPRAM_RD_ABORT_EN to add the abort/aborted ports.
module sdpram_rd_streamer
    import sdpram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  ram_rd_clk_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
`ifdef SDPRAM_RD_ABORT_EN
    ,
    input  logic                  abort,
    output logic                  aborted
`endif
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  adv;
    logic                  last_hs;
    logic                  abort_hit;

    // The RAM is clocked forward only when the output slot is empty or being drained.
    assign adv     = (state == ST_STREAM) && (!m_valid || m_ready);
    assign last_hs = m_valid && m_ready && m_last;

`ifdef SDPRAM_RD_ABORT_EN
    assign abort_hit = abort && (state == ST_STREAM);
`else
    assign abort_hit = 1'b0;
`endif

    assign cmd_ready     = (state == ST_IDLE) && !rd_rst;
    assign busy          = (state != ST_IDLE);
    assign ram_rd_clk_en = adv;
    assign ram_rd_addr   = rd_ptr;
    assign m_data        = ram_rd_data;

    // Burst FSM, address/length counters and registered stream flags.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            done      <= 1'b0;
`ifdef SDPRAM_RD_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SDPRAM_RD_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rd_ptr    <= cmd_addr;
                        remaining <= LEN_WIDTH'(clamp_len(32'(cmd_len), ADDR_WIDTH));
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (abort_hit) begin
                        remaining <= '0;
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                        state     <= ST_IDLE;
                        done      <= 1'b1;
`ifdef SDPRAM_RD_ABORT_EN
                        aborted   <= 1'b1;
`endif
                    end else if (last_hs) begin
                        state   <= ST_IDLE;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        done    <= 1'b1;
                    end else if (adv) begin
                        if (remaining != '0) begin
                            m_valid   <= 1'b1;
                            m_last    <= (remaining == LEN_WIDTH'(1));
                            rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                            remaining <= remaining - LEN_WIDTH'(1);
                        end else begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
